// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: one-cycle capture of Decode fields with load-use bubble
// insertion, external hold and flush. Bubble counter built only when IDEX_PERF_CNT_EN is defined.
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Stall_in,
  input  logic                  Flush_in,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_reg_data1,
  input  logic [DATA_W-1:0]     id_reg_data2,
  input  logic [DATA_W-1:0]     id_sign_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_shamt,
  input  logic [5:0]            id_func,
  input  logic                  id_alusrc,
  input  logic [1:0]            id_regdst,
  input  logic [3:0]            id_aluop,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  id_memtoreg,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_reg_data1,
  output logic [DATA_W-1:0]     ex_reg_data2,
  output logic [DATA_W-1:0]     ex_sign_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_shamt,
  output logic [5:0]            ex_func,
  output logic                  ex_alusrc,
  output logic [1:0]            ex_regdst,
  output logic [3:0]            ex_aluop,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_memtoreg,
  output logic                  hazard_stall,
  output logic [31:0]           perf_bubbles
);

  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned REGDST_W = 2;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned PERF_W   = 32;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     reg_data1;
    logic [DATA_W-1:0]     reg_data2;
    logic [DATA_W-1:0]     sign_ext;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] shamt;
    logic [FUNC_W-1:0]     func;
    logic                  alusrc;
    logic [REGDST_W-1:0]   regdst;
    logic [ALUOP_W-1:0]    aluop;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
  } ex_fields_t;

  ex_fields_t w_id;
  ex_fields_t r_ex;
  logic       w_hazard;
  logic       w_bubble;

  assign w_id = {id_valid, id_reg_data1, id_reg_data2, id_sign_ext,
                 id_rs, id_rt, id_rd, id_shamt, id_func, id_alusrc,
                 id_regdst, id_aluop, id_regwrite, id_memread,
                 id_memwrite, id_memtoreg};

  // Load in EX whose destination is a source of the instruction in Decode
  assign w_hazard = r_ex.valid & r_ex.memread & (r_ex.rt != '0)
                  & ((r_ex.rt == id_rs) | (r_ex.rt == id_rt))
                  & id_valid & ~Stall_in;

  // Flush overrides the hold; a hazard is already masked by the hold
  assign w_bubble = Flush_in | w_hazard;

  always_ff @(posedge Clk) begin
    if (Rst || w_bubble) begin
      r_ex <= '0;
    end else if (!Stall_in) begin
      r_ex <= id_valid ? w_id : '0;
    end
  end

  assign ex_valid     = r_ex.valid;
  assign ex_reg_data1 = r_ex.reg_data1;
  assign ex_reg_data2 = r_ex.reg_data2;
  assign ex_sign_ext  = r_ex.sign_ext;
  assign ex_rs        = r_ex.rs;
  assign ex_rt        = r_ex.rt;
  assign ex_rd        = r_ex.rd;
  assign ex_shamt     = r_ex.shamt;
  assign ex_func      = r_ex.func;
  assign ex_alusrc    = r_ex.alusrc;
  assign ex_regdst    = r_ex.regdst;
  assign ex_aluop     = r_ex.aluop;
  assign ex_regwrite  = r_ex.regwrite;
  assign ex_memread   = r_ex.memread;
  assign ex_memwrite  = r_ex.memwrite;
  assign ex_memtoreg  = r_ex.memtoreg;
  assign hazard_stall = w_hazard;

`ifdef IDEX_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_cnt;

  // Counts hazard and flush bubbles only; wraps naturally
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_perf_cnt <= '0;
    end else if (w_bubble) begin
      r_perf_cnt <= r_perf_cnt + PERF_W'(1);
    end
  end

  assign perf_bubbles = r_perf_cnt;
`else
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed + random bench for id_ex_pipeline_reg with an expected-value queue.
// Honours IDEX_PERF_CNT_EN to select the expected bubble-counter behaviour.
module tb_id_ex_pipeline_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] reg_data1;
    logic [DW-1:0] reg_data2;
    logic [DW-1:0] sign_ext;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] shamt;
    logic [5:0]    func;
    logic          alusrc;
    logic [1:0]    regdst;
    logic [3:0]    aluop;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } fields_t;

  typedef struct packed {
    fields_t     ex;
    logic [31:0] perf;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst, Stall_in, Flush_in;
  fields_t in;
  fields_t obs;

  logic          ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [DW-1:0] ex_reg_data1, ex_reg_data2, ex_sign_ext;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]    ex_func;
  logic [1:0]    ex_regdst;
  logic [3:0]    ex_aluop;
  logic          hazard_stall;
  logic [31:0]   perf_bubbles;

  int checks = 0;
  int errors = 0;

  fields_t     m_ex;
  logic [31:0] m_perf;
  exp_t        q[$];

  always #5 Clk = ~Clk;

  id_ex_pipeline_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Stall_in(Stall_in), .Flush_in(Flush_in),
    .id_valid(in.valid), .id_reg_data1(in.reg_data1), .id_reg_data2(in.reg_data2),
    .id_sign_ext(in.sign_ext), .id_rs(in.rs), .id_rt(in.rt), .id_rd(in.rd),
    .id_shamt(in.shamt), .id_func(in.func), .id_alusrc(in.alusrc),
    .id_regdst(in.regdst), .id_aluop(in.aluop), .id_regwrite(in.regwrite),
    .id_memread(in.memread), .id_memwrite(in.memwrite), .id_memtoreg(in.memtoreg),
    .ex_valid(ex_valid), .ex_reg_data1(ex_reg_data1), .ex_reg_data2(ex_reg_data2),
    .ex_sign_ext(ex_sign_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_func(ex_func), .ex_alusrc(ex_alusrc),
    .ex_regdst(ex_regdst), .ex_aluop(ex_aluop), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .hazard_stall(hazard_stall), .perf_bubbles(perf_bubbles)
  );

  assign obs = {ex_valid, ex_reg_data1, ex_reg_data2, ex_sign_ext, ex_rs, ex_rt,
                ex_rd, ex_shamt, ex_func, ex_alusrc, ex_regdst, ex_aluop,
                ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg};

  function automatic fields_t rand_id();
    fields_t t;
    t.valid     = 1'b1;
    t.reg_data1 = $urandom;
    t.reg_data2 = $urandom;
    t.sign_ext  = $urandom;
    t.rs        = AW'($urandom_range(0, 3));
    t.rt        = AW'($urandom_range(0, 3));
    t.rd        = AW'($urandom);
    t.shamt     = AW'($urandom);
    t.func      = 6'($urandom);
    t.alusrc    = 1'($urandom);
    t.regdst    = 2'($urandom_range(0, 2));
    t.aluop     = 4'($urandom);
    t.regwrite  = 1'($urandom);
    t.memread   = 1'($urandom);
    t.memwrite  = 1'($urandom);
    t.memtoreg  = 1'($urandom);
    return t;
  endfunction

  task automatic check_fields(input string tag, input fields_t o, input fields_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_bit32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock: check hazard_stall, predict next EX state, clock, compare
  task automatic step(input string tag);
    logic hz;
    exp_t e;
    #1;
    hz = m_ex.valid & m_ex.memread & (m_ex.rt != '0)
       & ((m_ex.rt == in.rs) | (m_ex.rt == in.rt)) & in.valid & ~Stall_in;
    if (!Rst) check_bit32({tag, "_hazard"}, 32'(hazard_stall), 32'(hz));
    if (Rst) begin
      m_ex = '0; m_perf = '0;
    end else if (Flush_in || hz) begin
      m_ex = '0;
`ifdef IDEX_PERF_CNT_EN
      m_perf = m_perf + 32'd1;
`endif
    end else if (!Stall_in) begin
      m_ex = in.valid ? in : '0;
    end
    q.push_back('{ex: m_ex, perf: m_perf});
    @(posedge Clk);
    #1;
    e = q.pop_front();
    check_fields({tag, "_ex"}, obs, e.ex);
    check_bit32({tag, "_perf"}, perf_bubbles, e.perf);
  endtask

  initial begin
    m_ex = '0; m_perf = '0;
    Stall_in = 1'b0; Flush_in = 1'b0;

    // Reset with every id field nonzero
    Rst = 1'b1;
    in = '1;
    step("reset");
    check_bit32("reset_valid", 32'(ex_valid), 32'd0);
    Rst = 1'b0;

    // Normal load
    in = rand_id();
    in.reg_data1 = 32'h12345678; in.aluop = 4'h2; in.rd = 5'd9; in.memread = 1'b0;
    step("normal");
    check_bit32("normal_data1", ex_reg_data1, 32'h12345678);
    check_bit32("normal_rd", 32'(ex_rd), 32'd9);

    // Load-use on rs: one bubble then the consumer loads
    in = rand_id(); in.memread = 1'b1; in.rt = 5'd8;
    step("load");
    in = rand_id(); in.memread = 1'b0; in.rs = 5'd8;
    step("lu_bubble");
    check_bit32("lu_bubble_valid", 32'(ex_valid), 32'd0);
    step("lu_reload");
    check_bit32("lu_reload_valid", 32'(ex_valid), 32'd1);

    // Load to $0 never stalls
    in = rand_id(); in.memread = 1'b1; in.rt = 5'd0;
    step("load0");
    in = rand_id(); in.rs = 5'd0; in.rt = 5'd0;
    step("load0_use");

    // Hold with an otherwise hazardous consumer
    in = rand_id(); in.memread = 1'b1; in.rt = 5'd8;
    step("load_h");
    Stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = rand_id(); in.rs = 5'd8;
      step("hold");
    end
    check_bit32("hold_rt", 32'(ex_rt), 32'd8);
    Flush_in = 1'b1;
    step("hold_flush");
    Stall_in = 1'b0; Flush_in = 1'b0;

    // Invalid Decode slot and a plain flush
    in = rand_id(); in.valid = 1'b0;
    step("invalid");
    in = rand_id();
    Flush_in = 1'b1;
    step("flush");
    Flush_in = 1'b0;

    // Reset during a pending hazard
    in = rand_id(); in.memread = 1'b1; in.rt = 5'd3;
    step("load_r");
    in = rand_id(); in.rs = 5'd3; Rst = 1'b1;
    step("rst_hazard");
    Rst = 1'b0;
    check_bit32("post_rst_hazard", 32'(hazard_stall), 32'd0);

`ifdef IDEX_PERF_CNT_EN
    // Counter wrap
    force dut.r_perf_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_cnt;
    m_perf = 32'hFFFF_FFFF;
    in = rand_id(); Flush_in = 1'b1;
    step("wrap");
    Flush_in = 1'b0;
`endif

    // Random mix
    for (int i = 0; i < 60; i++) begin
      in = rand_id();
      in.valid = ($urandom_range(0, 7) != 0);
      Stall_in = ($urandom_range(0, 5) == 0);
      Flush_in = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
